dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 113 +++++++++++
 tb/tb_dmem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   state_e               - responder FSM encoding (IDLE / BUSY / RESP)
//   DEPTH_WORDS_DEFAULT   - default number of 32-bit storage words
//   LATENCY_DEFAULT       - default acceptance-to-response latency in edges
//   CNT_W                 - width of the latency counter
package dmem_pkg;

    localparam int DEPTH_WORDS_DEFAULT = 256;
    localparam int LATENCY_DEFAULT     = 2;
    localparam int CNT_W               = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-addressed storage, synchronous write, asynchronous read.
// Contents are deliberately not reset so committed stores survive rst.
//   clk    - write clock
//   we     - write enable for addr on the rising edge
//   addr   - word index used for both read and write
//   wdata  - write data
//   rdata  - combinational read of the word at addr (pre-write value)
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed,
// parameterised response latency.
//   clk, rst              - clock, asynchronous active-high reset
//   req_valid/req_ready   - request handshake
//   req_write             - 1 = store, 0 = load
//   req_addr, req_wdata   - byte address, store data
//   resp_valid/resp_ready - response handshake
//   resp_rdata, resp_err  - load data (0 for stores/errors), error flag
//   dbg_state             - current FSM state for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready is 1 only in IDLE and never depends on req_valid;
// resp_valid is 1 only in RESP and never depends on resp_ready. Request
// fields are sampled only on the transfer edge, and response fields hold
// steady while resp_valid=1 and resp_ready=0.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int LATENCY     = LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output state_e      dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    // BUSY lasts LATENCY edges; the counter counts down to 0 inclusive.
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic             accept;
    logic             addr_err;
    logic             mem_we;
    logic [31:0]      mem_rdata;

    assign accept   = req_valid && (state == IDLE);
    // Misaligned or beyond the array: the full upper address is compared so
    // aliasing high addresses are rejected rather than wrapped.
    assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= DEPTH_LIM);
    assign mem_we   = accept && req_write && !addr_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (req_addr[AW+1:2]),
        .wdata (req_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Load data is the pre-edge array word; stores and
                        // errors report 0.
                        rdata_q <= (req_write || addr_err) ? 32'd0 : mem_rdata;
                        err_q   <= addr_err;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2/256-word instance and a
// LATENCY=0/16-word instance share one request/response bus selected by sel.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int L_A = 2;
    localparam int L_Z = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // shared bus
    bit          sel = 1'b0;
    logic        b_req_valid = 1'b0;
    logic        b_req_write = 1'b0;
    logic [31:0] b_req_addr  = '0;
    logic [31:0] b_req_wdata = '0;
    logic        b_resp_ready = 1'b1;
    logic        b_req_ready, b_resp_valid, b_resp_err;
    logic [31:0] b_resp_rdata;

    logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready, a_resp_err;
    logic [31:0] a_resp_rdata;
    logic [1:0]  a_dbg;
    logic        z_req_valid, z_req_ready, z_resp_valid, z_resp_ready, z_resp_err;
    logic [31:0] z_resp_rdata;
    logic [1:0]  z_dbg;

    assign a_req_valid  = !sel && b_req_valid;
    assign z_req_valid  =  sel && b_req_valid;
    assign a_resp_ready = !sel && b_resp_ready;
    assign z_resp_ready =  sel && b_resp_ready;
    assign b_req_ready  = sel ? z_req_ready  : a_req_ready;
    assign b_resp_valid = sel ? z_resp_valid : a_resp_valid;
    assign b_resp_rdata = sel ? z_resp_rdata : a_resp_rdata;
    assign b_resp_err   = sel ? z_resp_err   : a_resp_err;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(L_A)) dut (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .dbg_state(a_dbg)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(L_Z)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err),
        .dbg_state(z_dbg)
    );

    // acceptance monitor
    bit mon_en = 1'b0;
    int acc_q[$];
    always @(posedge clk) begin
        if (mon_en && b_req_valid && b_req_ready) acc_q.push_back(cyc);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request (called at a negedge); returns at a negedge in IDLE.
    task automatic transact(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic e,
                            output int lat, output int wait_n, output bit ok);
        b_req_valid = 1'b1; b_req_write = w; b_req_addr = a; b_req_wdata = d;
        b_resp_ready = 1'b1;
        wait_n = 0;
        while (!b_req_ready && wait_n < 40) begin @(negedge clk); wait_n++; end
        ok = 1'b0; rd = '0; e = 1'b0; lat = 0;
        if (!b_req_ready) begin b_req_valid = 1'b0; return; end
        @(posedge clk); #1 b_req_valid = 1'b0;
        @(negedge clk);
        while (!b_resp_valid && lat < 40) begin @(negedge clk); lat++; end
        ok = b_resp_valid; rd = b_resp_rdata; e = b_resp_err;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit          sel;
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic spacing_test(input int lat_cfg, input string name);
        int n;
        acc_q.delete();
        mon_en = 1'b1;
        b_resp_ready = 1'b1;
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h0; b_req_wdata = '0;
        n = 0;
        while (acc_q.size() < 4 && n < 100) begin @(negedge clk); n++; end
        b_req_valid = 1'b0;
        mon_en = 1'b0;
        repeat (lat_cfg + 3) @(negedge clk);
        chk({name, "_count"}, acc_q.size(), 4);
        if (acc_q.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk({name, "_gap"}, acc_q[i] - acc_q[i-1], lat_cfg + 2);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat, wait_n, exp_lat;
        bit          ok;
        logic [31:0] hold_rd;
        logic        hold_e;
        int          n;

        // store/load vectors with hand-computed results
        vecs.push_back('{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h0000_0000, 32'hA5A5_0001, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b0, 32'h0000_0013, 32'h0,         32'h0, 1'b1});
        vecs.push_back('{0, 1'b1, 32'h0000_0400, 32'hBAD0_BAD0, 32'h0, 1'b1});
        vecs.push_back('{0, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_0001, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h0000_03FC, 32'h1111_2222, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b0, 32'h0000_03FC, 32'h0,         32'h1111_2222, 1'b0});
        vecs.push_back('{0, 1'b0, 32'h0000_0400, 32'h0,         32'h0, 1'b1});
        vecs.push_back('{0, 1'b1, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0, 1'b1});
        vecs.push_back('{0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1});
        vecs.push_back('{0, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_0001, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1'b0});
        vecs.push_back('{0, 1'b0, 32'h8000_0010, 32'h0,         32'h0, 1'b1});
        vecs.push_back('{1, 1'b1, 32'h0000_0004, 32'h0BAD_F00D, 32'h0, 1'b0});
        vecs.push_back('{1, 1'b0, 32'h0000_0004, 32'h0,         32'h0BAD_F00D, 1'b0});
        vecs.push_back('{1, 1'b0, 32'h0000_0040, 32'h0,         32'h0, 1'b1});
        vecs.push_back('{1, 1'b1, 32'h0000_003C, 32'h0000_0077, 32'h0, 1'b0});
        vecs.push_back('{1, 1'b0, 32'h0000_003C, 32'h0,         32'h0000_0077, 1'b0});

        // clock/reset
        repeat (3) @(negedge clk);
        chk("rst_req_ready",  a_req_ready,  1'b1);
        chk("rst_resp_valid", a_resp_valid, 1'b0);
        chk("rst_rdata",      a_resp_rdata, 32'h0);
        chk("rst_err",        a_resp_err,   1'b0);
        chk("rst_state",      a_dbg,        IDLE);
        chk("rst0_req_ready", z_req_ready,  1'b1);
        rst = 1'b0;

        // table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            sel = vecs[i].sel;
            exp_lat = vecs[i].sel ? L_Z : L_A;
            transact(vecs[i].w, vecs[i].addr, vecs[i].wdata, rd, e, lat, wait_n, ok);
            chk($sformatf("v%0d_resp_seen", i), ok, 1'b1);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), e, vecs[i].exp_err);
            chk($sformatf("v%0d_latency", i), lat, exp_lat);
            if (i == 0) chk("first_accept_wait", wait_n, 0);
        end

        // response held under back-pressure while another request waits
        sel = 1'b0;
        b_resp_ready = 1'b0;
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h10; b_req_wdata = '0;
        @(posedge clk); #1;
        b_req_write = 1'b1; b_req_addr = 32'h0; b_req_wdata = 32'hFFFF_FFFF;
        n = 0;
        @(negedge clk);
        while (!b_resp_valid && n < 20) begin @(negedge clk); n++; end
        chk("hold_resp_seen", b_resp_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("hold_valid",     b_resp_valid, 1'b1);
            chk("hold_rdata",     b_resp_rdata, 32'hCAFE_F00D);
            chk("hold_err",       b_resp_err,   1'b0);
            chk("hold_req_ready", b_req_ready,  1'b0);
        end
        b_req_valid = 1'b0;
        b_resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_req_ready",  b_req_ready,  1'b1);
        chk("release_resp_valid", b_resp_valid, 1'b0);
        transact(1'b0, 32'h0, 32'h0, rd, e, lat, wait_n, ok);
        chk("ignored_store_rdata", rd, 32'hA5A5_0001);

        // back-to-back spacing on both latencies
        sel = 1'b0;
        spacing_test(L_A, "spacing_l2");
        sel = 1'b1;
        spacing_test(L_Z, "spacing_l0");

        // reset while BUSY discards the response but keeps the store
        sel = 1'b0;
        b_resp_ready = 1'b1;
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h8; b_req_wdata = 32'h1234_5678;
        @(posedge clk); #1 b_req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", a_dbg, BUSY);
        rst = 1'b1;
        #1;
        chk("mid_rst_state",      a_dbg,        IDLE);
        chk("mid_rst_req_ready",  a_req_ready,  1'b1);
        chk("mid_rst_resp_valid", a_resp_valid, 1'b0);
        chk("mid_rst_rdata",      a_resp_rdata, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("in_rst_resp_valid", a_resp_valid, 1'b0);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_resp_valid", a_resp_valid, 1'b0);
        end
        transact(1'b0, 32'h8, 32'h0, rd, e, lat, wait_n, ok);
        chk("post_rst_load_seen",  ok, 1'b1);
        chk("post_rst_load_rdata", rd, 32'h1234_5678);
        chk("post_rst_load_err",   e,  1'b0);
        transact(1'b0, 32'h0, 32'h0, rd, e, lat, wait_n, ok);
        chk("post_rst_word0", rd, 32'hA5A5_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // hard time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
